mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: Clk  in  1  pipeline clock; all state updates on the falling edge, matching the pipeline registers.
REQ-002 SHALL have ports: Rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have EX/MEM inputs: Branch_addr_MEM in 32; Condition_MEM in 3; Branch_MEM, MemWrite_MEM, RegWrite_MEM, MemRead_MEM in 1; MemData_MEM in 32 (store data); WBData_MEM in 32 (ALU result, also the memory address); Less_MEM, Zero_MEM, Overflow_MEM in 1; Rd_MEM in 5.
REQ-004 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_rdata in 32; dmem_ack in 1.
REQ-005 SHALL have pipeline-control outputs: stall out 1 (holds PC, IF/ID, ID/EX and EX/MEM); flush out 1 (branch taken, kill younger stages); PCSrc out 1; Branch_target out 32.
REQ-006 SHALL have MEM/WB outputs: RegWrite_WB out 1; WBData_WB out 32; Rd_WB out 5; mem_err out 1 (sticky).

Function
REQ-007 SHALL compute cond: 000 never; 001 Zero; 010 !Zero; 011 Less; 100 !Less; 101 Less|Zero; 110 !Less&!Zero; 111 always.
REQ-008 SHALL drive taken = Branch_MEM & cond, combinationally; flush = PCSrc = taken; Branch_target = Branch_addr_MEM.
REQ-009 SHALL define mem_op = MemRead_MEM | MemWrite_MEM; misalign = mem_op & (WBData_MEM[1:0] != 00).
REQ-010 SHALL implement FSM states IDLE, ACCESS, each transition on a falling edge.
REQ-011 IDLE -> ACCESS when mem_op & !misalign; otherwise it stays IDLE.
REQ-012 In ACCESS, dmem_req SHALL be 1; dmem_we = MemWrite_MEM; dmem_addr = WBData_MEM; dmem_wdata = MemData_MEM. All of these SHALL be 0 in IDLE.
REQ-013 ACCESS -> IDLE on the edge where dmem_ack=1, or on timeout.
REQ-014 A 4-bit wait counter SHALL clear on IDLE->ACCESS and increment each ACCESS cycle without ack. When it reaches 15 without ack, that edge is a timeout: set mem_err and return to IDLE.
REQ-015 stall SHALL be combinational: (IDLE & mem_op & !misalign) | (ACCESS & !dmem_ack & count!=15).
REQ-016 When a load receives ack, dmem_rdata SHALL be captured on that same edge.
REQ-017 On each edge with stall=0, the MEM/WB outputs SHALL load:
  - RegWrite_WB <= RegWrite_MEM & !Overflow_MEM & !misalign & !timeout;
  - WBData_WB <= MemRead_MEM ? dmem_rdata : WBData_MEM;
  - Rd_WB <= Rd_MEM.
REQ-018 On each edge with stall=1, the block SHALL insert a bubble: RegWrite_WB <= 0, while WBData_WB and Rd_WB hold.
REQ-019 A misaligned access SHALL make no memory request and raise no stall. It SHALL set mem_err, and its write-back is suppressed.
REQ-020 mem_err SHALL be sticky until reset.
REQ-021 If dmem_ack=1 while in IDLE, it SHALL be ignored.
REQ-022 A branch and a memory operation never coexist in one instruction; if both are asserted, the branch outputs SHALL still follow REQ-008.

Reset
REQ-023 Rst_n=0 SHALL immediately force:
  - state IDLE, counter 0;
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0;
  - RegWrite_WB=0, WBData_WB=0, Rd_WB=0, mem_err=0.
REQ-024 Reset asserted during ACCESS SHALL abort the access with no write-back. The first edge after release SHALL evaluate the inputs from IDLE.

Verification
REQ-025 Load: MemRead=1, WBData_MEM=0x100, RegWrite=1, Rd=5; ack with rdata=0xDEADBEEF on the 3rd ACCESS cycle.
  -> stall=1 for 3 cycles, then RegWrite_WB=1, WBData_WB=0xDEADBEEF, Rd_WB=5; one bubble per stalled cycle.
REQ-026 Store: MemWrite=1, addr=0x20, MemData=0x1234; ack on the 1st ACCESS cycle.
  -> dmem_we=1, dmem_wdata=0x1234, exactly one request cycle, RegWrite_WB=0.
REQ-027 Branch: Branch=1, Condition=001, Zero=1, Branch_addr=0x40.
  -> flush=PCSrc=1, Branch_target=0x40, stall=0.
  With Zero=0 -> flush=0.
REQ-028 Timeout: load with no ack.
  -> stall high for exactly 15 ACCESS cycles, then mem_err=1, RegWrite_WB=0, state IDLE.
REQ-029 Misaligned: load to 0x102.
  -> dmem_req never asserts, stall=0, mem_err=1, RegWrite_WB=0.
REQ-030 Rst_n pulsed low mid-ACCESS.
  -> dmem_req drops immediately, all outputs return to 0, and normal operation resumes.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM stage of the in-order pipeline. It resolves branches for the instruction
// sitting in EX/MEM, runs the handshake with the data memory for loads and
// stores, stalls the front of the pipeline while a memory access is
// outstanding, and owns the MEM/WB pipeline register.
//
// All state changes on the falling edge of Clk, like the rest of the pipeline
// registers. Rst_n is an asynchronous, active-low reset.
//
// Ports
//   Clk, Rst_n              clock (falling edge active), async active-low reset
//   Branch_addr_MEM         branch target computed in EX
//   Condition_MEM           3-bit branch condition selector
//   Branch_MEM              instruction is a branch
//   MemWrite_MEM            instruction is a store
//   MemRead_MEM             instruction is a load
//   RegWrite_MEM            instruction writes the register file
//   MemData_MEM             store data
//   WBData_MEM              ALU result; also the memory address
//   Less_MEM, Zero_MEM      ALU flags used by the branch condition
//   Overflow_MEM            ALU overflow; suppresses register write-back
//   Rd_MEM                  destination register
//   dmem_req/we/addr/wdata  request to data memory (valid while ACCESS)
//   dmem_rdata, dmem_ack    response from data memory
//   stall                   hold PC, IF/ID, ID/EX and EX/MEM
//   flush, PCSrc            branch taken: redirect PC and kill younger stages
//   Branch_target           redirect address
//   RegWrite_WB, WBData_WB,
//   Rd_WB                   MEM/WB pipeline register
//   mem_err                 sticky: misaligned access or memory timeout seen
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  // EX/MEM
  input  logic [DATA_W-1:0] Branch_addr_MEM,
  input  logic [2:0]        Condition_MEM,
  input  logic              Branch_MEM,
  input  logic              MemWrite_MEM,
  input  logic              RegWrite_MEM,
  input  logic              MemRead_MEM,
  input  logic [DATA_W-1:0] MemData_MEM,
  input  logic [DATA_W-1:0] WBData_MEM,
  input  logic              Less_MEM,
  input  logic              Zero_MEM,
  input  logic              Overflow_MEM,
  input  logic [4:0]        Rd_MEM,
  // Data memory
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  // Pipeline control
  output logic              stall,
  output logic              flush,
  output logic              PCSrc,
  output logic [DATA_W-1:0] Branch_target,
  // MEM/WB
  output logic              RegWrite_WB,
  output logic [DATA_W-1:0] WBData_WB,
  output logic [4:0]        Rd_WB,
  output logic              mem_err
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'hF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_cnt_nxt;

  logic        w_cond;
  logic        w_taken;
  logic        w_mem_op;
  logic        w_misalign;
  logic        w_wait_max;
  logic        w_timeout;
  logic        w_wb_regwrite;
  logic [DATA_W-1:0] w_wb_data;

  // Branch condition decode on the ALU flags.
  function automatic logic cond_eval(input logic [2:0] cond,
                                     input logic       zero,
                                     input logic       less);
    logic res;
    case (cond)
      3'b000:  res = 1'b0;
      3'b001:  res = zero;
      3'b010:  res = ~zero;
      3'b011:  res = less;
      3'b100:  res = ~less;
      3'b101:  res = less | zero;
      3'b110:  res = ~less & ~zero;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // ---- Branch resolution (combinational) ----
  assign w_cond        = cond_eval(Condition_MEM, Zero_MEM, Less_MEM);
  assign w_taken       = Branch_MEM & w_cond;
  assign flush         = w_taken;
  assign PCSrc         = w_taken;
  assign Branch_target = Branch_addr_MEM;

  // ---- Memory access qualification ----
  assign w_mem_op   = MemRead_MEM | MemWrite_MEM;
  assign w_misalign = w_mem_op & (WBData_MEM[1:0] != 2'b00);
  assign w_wait_max = (r_wait_cnt == WAIT_MAX);
  // Sixteenth ACCESS cycle with no ack: give up on this access.
  assign w_timeout  = (r_state == ST_ACCESS) & ~dmem_ack & w_wait_max;

  // ---- FSM next state, stall and memory request ----
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    stall          = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    case (r_state)
      ST_IDLE: begin
        // A stray ack while idle has no effect here.
        if (w_mem_op && !w_misalign) begin
          w_state_nxt    = ST_ACCESS;
          w_wait_cnt_nxt = 4'h0;
          stall          = 1'b1;
        end
      end
      ST_ACCESS: begin
        // EX/MEM is frozen by stall, so these inputs stay stable for the
        // whole access.
        dmem_req   = 1'b1;
        dmem_we    = MemWrite_MEM;
        dmem_addr  = WBData_MEM;
        dmem_wdata = MemData_MEM;
        if (dmem_ack) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wait_max) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 4'h1;
          stall          = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---- MEM/WB next values ----
  // On the ack edge of a load, stall is low, so the read data is captured
  // on that same edge.
  assign w_wb_regwrite = RegWrite_MEM & ~Overflow_MEM & ~w_misalign & ~w_timeout;
  assign w_wb_data     = MemRead_MEM ? dmem_rdata : WBData_MEM;

  // ---- State register ----
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // ---- MEM/WB register and error flag ----
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RegWrite_WB <= 1'b0;
      WBData_WB   <= '0;
      Rd_WB       <= 5'd0;
      mem_err     <= 1'b0;
    end else begin
      if (stall) begin
        // Bubble: no write-back, data and destination hold.
        RegWrite_WB <= 1'b0;
      end else begin
        RegWrite_WB <= w_wb_regwrite;
        WBData_WB   <= w_wb_data;
        Rd_WB       <= Rd_MEM;
      end
      if (((r_state == ST_IDLE) && w_misalign) || w_timeout) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Branch_addr_MEM;
  logic [2:0]  Condition_MEM;
  logic        Branch_MEM, MemWrite_MEM, RegWrite_MEM, MemRead_MEM;
  logic [31:0] MemData_MEM, WBData_MEM;
  logic        Less_MEM, Zero_MEM, Overflow_MEM;
  logic [4:0]  Rd_MEM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, flush, PCSrc;
  logic [31:0] Branch_target;
  logic        RegWrite_WB;
  logic [31:0] WBData_WB;
  logic [4:0]  Rd_WB;
  logic        mem_err;

  mem_access_unit dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Branch_addr_MEM(Branch_addr_MEM), .Condition_MEM(Condition_MEM),
    .Branch_MEM(Branch_MEM), .MemWrite_MEM(MemWrite_MEM),
    .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM),
    .MemData_MEM(MemData_MEM), .WBData_MEM(WBData_MEM),
    .Less_MEM(Less_MEM), .Zero_MEM(Zero_MEM), .Overflow_MEM(Overflow_MEM),
    .Rd_MEM(Rd_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .flush(flush), .PCSrc(PCSrc), .Branch_target(Branch_target),
    .RegWrite_WB(RegWrite_WB), .WBData_WB(WBData_WB), .Rd_WB(Rd_WB),
    .mem_err(mem_err)
  );

  // Active edge is the falling edge; outputs are sampled on the rising edge.
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        br;
    logic [2:0]  cond;
    logic        zero;
    logic        less;
    logic        ovf;
    logic [31:0] baddr;
    logic        ld;
    logic        st;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic       br;
    logic [2:0] cond;
    logic       zero;
    logic       less;
    logic       exp_taken;
  } br_vec_t;

  // Reference state of the MEM/WB register and error flag.
  logic        m_rw;
  logic [31:0] m_wbdata;
  logic [4:0]  m_rd;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic ref_taken(input logic br, input logic [2:0] c,
                                     input logic z, input logic l);
    logic t;
    case (c)
      3'd0: t = 0;
      3'd1: t = z;
      3'd2: t = !z;
      3'd3: t = l;
      3'd4: t = !l;
      3'd5: t = l || z;
      3'd6: t = !l && !z;
      default: t = 1;
    endcase
    return br && t;
  endfunction

  function automatic instr_t nop_instr();
    instr_t n;
    n = '{br:0, cond:0, zero:0, less:0, ovf:0, baddr:0, ld:0, st:0, rw:0,
          addr:0, wdata:0, rd:0};
    return n;
  endfunction

  task automatic apply(input instr_t in);
    Branch_MEM      = in.br;
    Condition_MEM   = in.cond;
    Zero_MEM        = in.zero;
    Less_MEM        = in.less;
    Overflow_MEM    = in.ovf;
    Branch_addr_MEM = in.baddr;
    MemRead_MEM     = in.ld;
    MemWrite_MEM    = in.st;
    RegWrite_MEM    = in.rw;
    WBData_MEM      = in.addr;
    MemData_MEM     = in.wdata;
    Rd_MEM          = in.rd;
  endtask

  // Runs one instruction through MEM. ack_at is the ACCESS cycle (1-based)
  // on which memory acknowledges; beyond 16 the access times out.
  task automatic run_instr(input instr_t in, input int ack_at, input bit spur_ack,
                           input bit fix_rd, input logic [31:0] fix_val,
                           output int n_stall, output int n_req, output int n_acc_stall);
    bit mem, mis, go, tmo;
    int n;
    logic [31:0] last_rdata;
    mem = in.ld || in.st;
    mis = mem && (in.addr[1:0] != 2'b00);
    go  = mem && !mis;
    n   = go ? ((ack_at < 16) ? ack_at : 16) + 1 : 1;
    tmo = go && (ack_at > 16);
    n_stall = 0; n_req = 0; n_acc_stall = 0;
    last_rdata = 0;
    apply(in);
    for (int c = 0; c < n; c++) begin
      dmem_ack   = (c == ack_at) || (c == 0 && spur_ack);
      dmem_rdata = fix_rd ? fix_val : $urandom;
      last_rdata = dmem_rdata;
      @(posedge Clk);
      if (stall) n_stall++;
      if (dmem_req) n_req++;
      if (stall && dmem_req) n_acc_stall++;
      chk("stall", stall, (c < n - 1));
      chk("dmem_req", dmem_req, (go && c >= 1));
      chk("dmem_we", dmem_we, (go && c >= 1) ? in.st : 1'b0);
      chk("dmem_addr", dmem_addr, (go && c >= 1) ? in.addr : 32'h0);
      chk("dmem_wdata", dmem_wdata, (go && c >= 1) ? in.wdata : 32'h0);
      if (c == 0) begin
        chk("flush", flush, ref_taken(in.br, in.cond, in.zero, in.less));
        chk("PCSrc", PCSrc, ref_taken(in.br, in.cond, in.zero, in.less));
        chk("Branch_target", Branch_target, in.baddr);
      end else begin
        chk("bubble_regwrite", RegWrite_WB, 1'b0);
        chk("bubble_rd_hold", Rd_WB, m_rd);
      end
      @(negedge Clk); #1;
    end
    dmem_ack = 0;
    m_rw     = in.rw && !in.ovf && !mis && !tmo;
    m_wbdata = in.ld ? last_rdata : in.addr;
    m_rd     = in.rd;
    m_err    = m_err || mis || tmo;
    chk("RegWrite_WB", RegWrite_WB, m_rw);
    chk("WBData_WB", WBData_WB, m_wbdata);
    chk("Rd_WB", Rd_WB, m_rd);
    chk("mem_err", mem_err, m_err);
    apply(nop_instr());
  endtask

  br_vec_t bv[17];
  instr_t  ins;
  int      ns, nr, nas;

  initial begin
    bv[0]  = '{1, 3'd0, 1, 1, 0};
    bv[1]  = '{1, 3'd1, 1, 0, 1};
    bv[2]  = '{1, 3'd1, 0, 0, 0};
    bv[3]  = '{1, 3'd2, 0, 0, 1};
    bv[4]  = '{1, 3'd2, 1, 0, 0};
    bv[5]  = '{1, 3'd3, 0, 1, 1};
    bv[6]  = '{1, 3'd3, 0, 0, 0};
    bv[7]  = '{1, 3'd4, 0, 0, 1};
    bv[8]  = '{1, 3'd4, 0, 1, 0};
    bv[9]  = '{1, 3'd5, 1, 0, 1};
    bv[10] = '{1, 3'd5, 0, 1, 1};
    bv[11] = '{1, 3'd5, 0, 0, 0};
    bv[12] = '{1, 3'd6, 0, 0, 1};
    bv[13] = '{1, 3'd6, 1, 0, 0};
    bv[14] = '{1, 3'd6, 0, 1, 0};
    bv[15] = '{1, 3'd7, 0, 0, 1};
    bv[16] = '{0, 3'd7, 1, 1, 0};

    // Reset state, with a load presented while reset is held.
    Rst_n = 0; dmem_ack = 0; dmem_rdata = 32'hFFFF_FFFF;
    ins = nop_instr(); ins.ld = 1; ins.addr = 32'h100; ins.rw = 1; ins.rd = 5'd9;
    apply(ins);
    #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_RegWrite_WB", RegWrite_WB, 0);
    chk("rst_WBData_WB", WBData_WB, 0);
    chk("rst_Rd_WB", Rd_WB, 0);
    chk("rst_mem_err", mem_err, 0);
    apply(nop_instr());
    m_rw = 0; m_wbdata = 0; m_rd = 0; m_err = 0;
    @(posedge Clk); #2 Rst_n = 1;
    @(negedge Clk); #1;

    // Branch condition table.
    for (int i = 0; i < 17; i++) begin
      ins = nop_instr();
      ins.br = bv[i].br; ins.cond = bv[i].cond;
      ins.zero = bv[i].zero; ins.less = bv[i].less;
      ins.baddr = 32'h40 + 32'(i * 4);
      apply(ins);
      @(posedge Clk);
      chk("tbl_flush", flush, bv[i].exp_taken);
      chk("tbl_PCSrc", PCSrc, bv[i].exp_taken);
      chk("tbl_target", Branch_target, 32'h40 + 32'(i * 4));
      chk("tbl_stall", stall, 0);
      @(negedge Clk); #1;
    end
    apply(nop_instr());

    // Load with ack on third ACCESS cycle.
    ins = nop_instr(); ins.ld = 1; ins.addr = 32'h100; ins.rw = 1; ins.rd = 5'd5;
    run_instr(ins, 3, 0, 1, 32'hDEADBEEF, ns, nr, nas);
    chk("load_stall_cycles", ns, 3);
    chk("load_data", WBData_WB, 32'hDEADBEEF);
    chk("load_rd", Rd_WB, 5);
    chk("load_regwrite", RegWrite_WB, 1);

    // Store with ack on first ACCESS cycle.
    ins = nop_instr(); ins.st = 1; ins.addr = 32'h20; ins.wdata = 32'h1234; ins.rd = 5'd3;
    run_instr(ins, 1, 1, 0, 0, ns, nr, nas);
    chk("store_req_cycles", nr, 1);
    chk("store_regwrite", RegWrite_WB, 0);

    // Branch with Zero set, then clear.
    ins = nop_instr(); ins.br = 1; ins.cond = 3'd1; ins.zero = 1; ins.baddr = 32'h40;
    run_instr(ins, 1, 0, 0, 0, ns, nr, nas);
    chk("branch_stall_cycles", ns, 0);
    ins.zero = 0;
    run_instr(ins, 1, 0, 0, 0, ns, nr, nas);

    // Misaligned load.
    ins = nop_instr(); ins.ld = 1; ins.addr = 32'h102; ins.rw = 1; ins.rd = 5'd7;
    run_instr(ins, 1, 0, 0, 0, ns, nr, nas);
    chk("misalign_req_cycles", nr, 0);
    chk("misalign_err", mem_err, 1);
    chk("misalign_regwrite", RegWrite_WB, 0);

    // Reset pulsed in the middle of an access.
    ins = nop_instr(); ins.ld = 1; ins.addr = 32'h200; ins.rw = 1; ins.rd = 5'd11;
    apply(ins);
    @(negedge Clk); #1;
    @(posedge Clk);
    chk("midrst_req_before", dmem_req, 1);
    #2 Rst_n = 0;
    #1;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_addr", dmem_addr, 0);
    chk("midrst_RegWrite_WB", RegWrite_WB, 0);
    chk("midrst_WBData_WB", WBData_WB, 0);
    chk("midrst_Rd_WB", Rd_WB, 0);
    chk("midrst_mem_err", mem_err, 0);
    apply(nop_instr());
    @(posedge Clk); #1 Rst_n = 1;
    @(negedge Clk); #1;
    m_rw = 0; m_wbdata = 0; m_rd = 0; m_err = 0;
    ins = nop_instr(); ins.ld = 1; ins.addr = 32'h204; ins.rw = 1; ins.rd = 5'd12;
    run_instr(ins, 2, 0, 0, 0, ns, nr, nas);
    chk("postrst_regwrite", RegWrite_WB, 1);

    // Randomized instruction stream against the reference model.
    for (int k = 0; k < 60; k++) begin
      int kind, ack_at;
      ins.br    = ($urandom_range(0, 3) == 0);
      ins.cond  = 3'($urandom_range(0, 7));
      ins.zero  = 1'($urandom_range(0, 1));
      ins.less  = 1'($urandom_range(0, 1));
      ins.ovf   = ($urandom_range(0, 5) == 0);
      ins.baddr = $urandom;
      ins.rw    = 1'($urandom_range(0, 1));
      ins.wdata = $urandom;
      ins.rd    = 5'($urandom_range(0, 31));
      ins.addr  = $urandom;
      kind      = $urandom_range(0, 3);
      ins.ld    = (kind == 1);
      ins.st    = (kind == 2);
      if (kind == 3) ins.br = 1;
      if ((kind == 1 || kind == 2) && $urandom_range(0, 4) != 0) ins.addr[1:0] = 2'b00;
      ack_at = $urandom_range(1, 6);
      if ($urandom_range(0, 14) == 0) ack_at = 16;
      if ($urandom_range(0, 14) == 0) ack_at = 40;
      run_instr(ins, ack_at, 1'($urandom_range(0, 1)), 0, 0, ns, nr, nas);
    end

    // Load that never gets an ack.
    ins = nop_instr(); ins.ld = 1; ins.addr = 32'h300; ins.rw = 1; ins.rd = 5'd4;
    run_instr(ins, 1000, 0, 0, 0, ns, nr, nas);
    chk("timeout_access_stalls", nas, 15);
    chk("timeout_req_cycles", nr, 16);
    chk("timeout_err", mem_err, 1);
    chk("timeout_regwrite", RegWrite_WB, 0);
    // Back in IDLE: a plain ALU op must pass without stall or request.
    ins = nop_instr(); ins.rw = 1; ins.addr = 32'h55; ins.rd = 5'd6;
    run_instr(ins, 1, 0, 0, 0, ns, nr, nas);
    chk("after_timeout_regwrite", RegWrite_WB, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
